// File: rtl/frame_receiver_if.sv
// Word stream from the FIFO read side into frame_receiver, plus its payload,
// per-frame status and statistics outputs.
interface frame_receiver_if;
  logic        data_2_valid;
  logic [15:0] data_2;
  logic        pl_valid;
  logic [15:0] pl_data;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] ok_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;

  modport master (
    output data_2_valid, data_2,
    input  pl_valid, pl_data, frame_done, frame_ok, err_code,
    input  ok_count, err_count, drop_count
  );

  modport slave (
    input  data_2_valid, data_2,
    output pl_valid, pl_data, frame_done, frame_ok, err_code,
    output ok_count, err_count, drop_count
  );
endinterface

// File: rtl/frame_receiver.sv
// Frame delineator on the FIFO read side: header / payload / checksum, with
// payload forwarding, per-frame status and saturating statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | discarding words until a legal header arrives
// PAYLOAD | forwarding payload words, accumulating the checksum
// CHECK   | waiting for the checksum word
module frame_receiver #(
  parameter int          MAX_LEN = 64,
  parameter int          TIMEOUT = 255,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic            clk_2,
  input  logic            reset,
  frame_receiver_if.slave fr
);

  localparam logic [7:0]  MAX_LEN_W = 8'(MAX_LEN);
  // Idle timer is a down-counter; zero on an idle cycle means TIMEOUT idle cycles elapsed.
  localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  remaining_q;
  logic [15:0] sum_q;
  logic [15:0] idle_q;

  logic hdr_legal;
  logic sum_match;
  logic hdr_take;
  logic pl_take;
  logic chk_take;
  logic drop_take;
  logic timeout_hit;
  logic idle_dec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hdr_legal = (fr.data_2[15:8] == SYNC) &&
                     (fr.data_2[7:0] != 8'd0) &&
                     (fr.data_2[7:0] <= MAX_LEN_W);
  assign sum_match = (fr.data_2 == sum_q);

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_take    = 1'b0;
    pl_take     = 1'b0;
    chk_take    = 1'b0;
    drop_take   = 1'b0;
    timeout_hit = 1'b0;
    idle_dec    = 1'b0;
    case (state_q)
      HUNT: begin
        if (fr.data_2_valid) begin
          if (hdr_legal) begin
            hdr_take = 1'b1;
            state_d  = PAYLOAD;
          end else begin
            drop_take = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (fr.data_2_valid) begin
          pl_take = 1'b1;
          if (remaining_q == 8'd1) begin
            state_d = CHECK;
          end
        end else if (idle_q == 16'd0) begin
          timeout_hit = 1'b1;
          state_d     = HUNT;
        end else begin
          idle_dec = 1'b1;
        end
      end
      CHECK: begin
        if (fr.data_2_valid) begin
          chk_take = 1'b1;
          state_d  = HUNT;
        end else if (idle_q == 16'd0) begin
          timeout_hit = 1'b1;
          state_d     = HUNT;
        end else begin
          idle_dec = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      remaining_q   <= 8'd0;
      sum_q         <= 16'd0;
      idle_q        <= 16'd0;
      fr.pl_valid   <= 1'b0;
      fr.pl_data    <= 16'd0;
      fr.frame_done <= 1'b0;
      fr.frame_ok   <= 1'b0;
      fr.err_code   <= 2'b00;
      fr.ok_count   <= 16'd0;
      fr.err_count  <= 16'd0;
      fr.drop_count <= 16'd0;
    end else begin
      fr.pl_valid   <= pl_take;
      fr.frame_done <= chk_take | timeout_hit;

      if (hdr_take) begin
        remaining_q <= fr.data_2[7:0];
        sum_q       <= fr.data_2;
      end

      if (pl_take) begin
        remaining_q <= remaining_q - 8'd1;
        sum_q       <= sum_q + fr.data_2;
        fr.pl_data  <= fr.data_2;
      end

      if (hdr_take || pl_take || chk_take) begin
        idle_q <= IDLE_LOAD;
      end else if (idle_dec) begin
        idle_q <= idle_q - 16'd1;
      end

      if (chk_take) begin
        fr.frame_ok <= sum_match;
        if (sum_match) begin
          fr.err_code <= 2'b00;
          fr.ok_count <= sat_inc(fr.ok_count);
        end else begin
          fr.err_code  <= 2'b01;
          fr.err_count <= sat_inc(fr.err_count);
        end
      end

      if (timeout_hit) begin
        fr.frame_ok  <= 1'b0;
        fr.err_code  <= 2'b10;
        fr.err_count <= sat_inc(fr.err_count);
      end

      if (drop_take) begin
        fr.drop_count <= sat_inc(fr.drop_count);
      end
    end
  end

endmodule
